// File: rtl/multimode_spike_encoder.sv
// Pixel-to-spike encoder: loads N_CH pixels, then emits TIME_STEPS spike vectors (rate or TTFS).
// Optional macro SPIKE_ENC_REFRACTORY_EN adds a one-step refractory period in rate mode.
module multimode_spike_encoder #(
  parameter int          N_CH       = 64,
  parameter int          PIX_W      = 8,
  parameter int          TIME_STEPS = 100,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PIX_W-1:0]              pix_data,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic                          mode,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          step_pulse,
  output logic [N_CH-1:0]               spike_out,
  output logic                          spike_valid,
  output logic [$clog2(TIME_STEPS)-1:0] step_idx,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int SW  = $clog2(TIME_STEPS);
  localparam int PW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int MW  = PIX_W + 17;
  localparam logic [PIX_W-1:0] PMAX = '1;

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_LOADED = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  function automatic logic [15:0] f_seed(input int ch);
    logic [15:0] s;
    s = LFSR_SEED ^ 16'((ch + 1) * 32'h9E37);
    return (s == 16'h0) ? 16'h0001 : s;
  endfunction

  function automatic logic [15:0] f_next(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [SW-1:0] f_lat(input logic [PIX_W-1:0] p);
    logic [MW-1:0] prod;
    prod = MW'(PMAX - p) * MW'(TIME_STEPS);
    return SW'(prod >> PIX_W);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             pend_q, pend_d;
  logic             sv_q, sv_d;
  logic             fd_q, fd_d;
  logic [SW-1:0]    idx_q, idx_d;
  logic [N_CH-1:0]  spk_q, spk_d, spk_calc;
  logic [PIX_W-1:0] pix_q [N_CH];
  logic [15:0]      lfsr_q [N_CH];
  logic [15:0]      lfsr_d [N_CH];
  logic [SW-1:0]    lat_q [N_CH];
  logic [SW-1:0]    lat_d [N_CH];
  logic             xfer;
`ifdef SPIKE_ENC_REFRACTORY_EN
  logic [N_CH-1:0]  ref_q, ref_d;
`endif

  assign pix_ready   = (state_q == S_LOAD);
  assign busy        = (state_q == S_RUN);
  assign spike_out   = spk_q;
  assign spike_valid = sv_q;
  assign step_idx    = idx_q;
  assign frame_done  = fd_q;
  assign xfer        = pix_valid & pix_ready & ~abort;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      spk_calc[i] = mode_q
        ? ((pix_q[i] != '0) && (cnt_q == lat_q[i]))
        : (lfsr_q[i][PIX_W-1:0] < pix_q[i]);
`ifdef SPIKE_ENC_REFRACTORY_EN
      if (!mode_q) spk_calc[i] = spk_calc[i] & ~ref_q[i];
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    sv_d    = 1'b0;
    fd_d    = 1'b0;
    idx_d   = idx_q;
    spk_d   = spk_q;
    for (int i = 0; i < N_CH; i++) begin
      lfsr_d[i] = lfsr_q[i];
      lat_d[i]  = lat_q[i];
    end
`ifdef SPIKE_ENC_REFRACTORY_EN
    ref_d = ref_q;
`endif
    if (abort) begin
      state_d = S_LOAD;
      ptr_d   = '0;
      pend_d  = 1'b0;
      spk_d   = '0;
`ifdef SPIKE_ENC_REFRACTORY_EN
      ref_d   = '0;
`endif
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (xfer) begin
            ptr_d = ptr_q + PW'(1);
            if (ptr_q == PW'(N_CH - 1)) begin
              state_d = S_LOADED;
              ptr_d   = '0;
            end
          end
        end
        S_LOADED: begin
          if (start) begin
            state_d = S_RUN;
            mode_d  = mode;
            cnt_d   = '0;
            for (int i = 0; i < N_CH; i++) begin
              lfsr_d[i] = f_seed(i);
              lat_d[i]  = f_lat(pix_q[i]);
            end
`ifdef SPIKE_ENC_REFRACTORY_EN
            ref_d = '0;
`endif
          end
        end
        S_RUN: begin
          // the cycle after the last strobe closes the frame
          if (pend_q) begin
            fd_d    = 1'b1;
            state_d = S_LOAD;
            ptr_d   = '0;
            pend_d  = 1'b0;
            spk_d   = '0;
          end else if (step_pulse) begin
            sv_d  = 1'b1;
            idx_d = cnt_q;
            spk_d = spk_calc;
            for (int i = 0; i < N_CH; i++) lfsr_d[i] = f_next(lfsr_q[i]);
`ifdef SPIKE_ENC_REFRACTORY_EN
            ref_d = mode_q ? '0 : spk_calc;
`endif
            if (cnt_q == SW'(TIME_STEPS - 1)) pend_d = 1'b1;
            else cnt_d = cnt_q + SW'(1);
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) pix_q[ptr_q] <= pix_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      ptr_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      pend_q  <= 1'b0;
      sv_q    <= 1'b0;
      fd_q    <= 1'b0;
      idx_q   <= '0;
      spk_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        lfsr_q[i] <= f_seed(i);
        lat_q[i]  <= '0;
      end
`ifdef SPIKE_ENC_REFRACTORY_EN
      ref_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      sv_q    <= sv_d;
      fd_q    <= fd_d;
      idx_q   <= idx_d;
      spk_q   <= spk_d;
      for (int i = 0; i < N_CH; i++) begin
        lfsr_q[i] <= lfsr_d[i];
        lat_q[i]  <= lat_d[i];
      end
`ifdef SPIKE_ENC_REFRACTORY_EN
      ref_q <= ref_d;
`endif
    end
  end

endmodule

// File: doc/multimode_spike_encoder.md
Name: multimode_spike_encoder

Overview:
Parametrised successor to the single-mode pixel-to-spike encoder. Accepts N_CH pixel values over a valid/ready stream, then on start emits TIME_STEPS spike vectors, one per step_pulse. Two runtime-selected codings: rate (per-channel LFSR Bernoulli) and time-to-first-spike (TTFS). Sits between the frame buffer / DMA and the first SNN neuron layer.

Parameters:
N_CH, 64, number of input channels (pixels per frame)
PIX_W, 8, pixel width in bits
TIME_STEPS, 100, steps per frame (2..65535)
LFSR_SEED, 16'hACE1, base seed for per-channel LFSRs

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pix_data  in  PIX_W  pixel value, channel order 0..N_CH-1
pix_valid  in  1  pix_data valid
pix_ready  out  1  encoder accepts a pixel
mode  in  1  0 = rate, 1 = TTFS; sampled on accepted start
start  in  1  begin frame; single-cycle pulse
abort  in  1  cancel load/run, return to LOAD
step_pulse  in  1  advance one time step
spike_out  out  N_CH  spike vector for current step
spike_valid  out  1  one-cycle strobe, spike_out valid
step_idx  out  SW=$clog2(TIME_STEPS)  index of the step on spike_out
busy  out  1  high in RUN
frame_done  out  1  one-cycle pulse after last step's spike_valid

Behaviour:
- Reset (async, rst_n low): state LOAD, load pointer 0, step counter 0, LFSRs at seeds, every output 0 except pix_ready = 1 (first cycle after release); pixel store contents don't-care.
- States: LOAD -> LOADED -> RUN -> LOAD.
- LOAD: pix_ready = 1; transfer on pix_valid & pix_ready writes channel[ptr], ptr++. Transfer at ptr = N_CH-1 -> LOADED, pix_ready = 0 next cycle.
- LOADED: start -> RUN; latch mode; step counter = 0; reload all LFSRs to seeds (deterministic per frame). start in LOAD or RUN ignored.
- RUN: busy = 1. On step_pulse: spike_out computed, spike_valid = 1 and step_idx = step counter one cycle later (latency 1). Counter increments. Step_pulse at counter = TIME_STEPS-1: the final spike_valid is followed by a frame_done pulse in the next cycle, state -> LOAD, ptr = 0. step_pulse outside RUN ignored.
- Rate: per-channel 16-bit Galois LFSR, polynomial mask 16'hB400, seed_ch = LFSR_SEED ^ ((ch+1)*16'h9E37) truncated to 16 bits, replaced by 16'h0001 if zero. Each LFSR advances once per step_pulse. Spike[ch] = (lfsr_ch[PIX_W-1:0] < pix[ch]). pix = 0 never fires. Larger pixel -> more spikes.
- TTFS: lat[ch] = ((2^PIX_W-1 - pix[ch]) * TIME_STEPS) >> PIX_W, computed at start, width SW. Spike[ch] = 1 only at step == lat[ch] and pix[ch] != 0; at most one spike per channel per frame.
- spike_out holds its value between strobes; it is cleared to 0 on frame_done and on abort.
- abort (any state): next cycle LOAD, ptr = 0, spike_valid/busy/frame_done = 0. abort beats simultaneous start/step_pulse/pixel transfer (transfer discarded).
- step_pulse and start in the same cycle in LOADED: start accepted, step_pulse ignored.
- No backpressure on spikes: consumer must take spike_valid strobes.

Optional Feature:
SPIKE_ENC_REFRACTORY_EN: when defined, rate mode adds a one-step refractory period. A channel that spiked at step t is forced to 0 at step t+1; its LFSR still advances. The refractory flags clear at start and on abort. TTFS is unaffected. When not defined, there is no refractory logic and channels are independent Bernoulli per step.

Test Plan:
- N_CH=4: load {0,255,128,64} with pix_valid gapped every other cycle -> exactly 4 transfers, then pix_ready = 0. Assert start plus 100 step_pulses in rate mode. Check: channel 0 spike count = 0; channel 1 >= 95; channel 2 in 35..65; channel 3 < channel 2; frame_done appears once, 1 cycle after the step_idx = 99 strobe.
- TTFS, same pixels -> ch1 fires only at step 0, ch2 only at step 49, ch3 only at step 74, ch0 never.
- Run the same frame twice in rate mode -> identical spike_out sequences (LFSR reload at start).
- abort at step 40 -> next cycle busy = 0, spike_out = 0, pix_ready = 1. Further step_pulses give no spike_valid. A fresh load is accepted.
- start while in LOAD (2 of 4 pixels loaded) -> ignored; step_pulse in LOADED -> no spike_valid. Assert rst_n mid-RUN -> all outputs 0 immediately, pix_ready = 1 after release.
- With SPIKE_ENC_REFRACTORY_EN, pix = 255 rate mode -> no two consecutive steps spike on a channel, count in 45..50; without the macro, count >= 95.
